// File: rtl/tx_arbiter_pkg.sv
// Shared types and constants for the TX link arbiter.
// State encodings are fixed so other blocks can decode them.
package tx_arbiter_pkg;

    localparam int N_REQ_DEF = 2;
    localparam int TO_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        DRAIN = 2'd2,
        GAP   = 2'd3
    } state_t;

endpackage

// File: rtl/tx_arbiter_rr_pick.sv
// Round-robin winner search starting just after rr_ptr.
// Purely combinational; found flags any requester.
module tx_arbiter_rr_pick
    import tx_arbiter_pkg::*;
#(
    parameter int N = N_REQ_DEF,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] rr_ptr,
    output logic [IW-1:0] idx,
    output logic          found
);

    logic [IW-1:0] j;

    // Scan from the far end so the nearest requester is written last.
    always_comb begin
        idx = '0;
        found = 1'b0;
        j = '0;
        for (int k = N; k >= 1; k--) begin
            j = IW'((int'(rr_ptr) + k) % N);
            if (req[j]) begin
                idx = j;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tx_arbiter.sv
// Packet-atomic round-robin arbiter for the shared byte-serial TX link.
// Registered output stage, inter-packet gap and mid-packet stall watchdog.
module tx_arbiter
    import tx_arbiter_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int GAP_CYCLES = 2,
    parameter int TIMEOUT = 1000,
    localparam int IW = $clog2(N_REQ)
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [N_REQ-1:0]   req_last,
    input  logic [8*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]   req_ready,
    output logic [7:0]         tx_data,
    output logic               tx_valid,
    input  logic               tx_ready,
    output logic [N_REQ-1:0]   grant,
    output logic               busy,
    output logic               err_timeout,
    output logic [IW-1:0]      err_src
);

    state_t state, state_n;
    logic [IW-1:0] rr_ptr, rr_ptr_n;
    logic [IW-1:0] owner, owner_n;
    logic [IW-1:0] err_src_n;
    logic [IW-1:0] win;
    logic found;
    logic [TO_W-1:0] stall_cnt, stall_cnt_n;
    logic [TO_W-1:0] gap_cnt, gap_cnt_n;
    logic [7:0] tx_data_n;
    logic tx_valid_n;
    logic [N_REQ-1:0] own_oh;
    logic own_valid, own_last, own_ready;
    logic load, stall;
    logic [7:0] own_data;

    tx_arbiter_rr_pick #(
        .N(N_REQ),
        .IW(IW)
    ) u_pick (
        .req(req_valid),
        .rr_ptr(rr_ptr),
        .idx(win),
        .found(found)
    );

    assign own_oh = {{(N_REQ-1){1'b0}}, 1'b1} << owner;
    assign own_valid = req_valid[owner];
    assign own_last = req_last[owner];
    assign own_data = req_data[{owner, 3'b000} +: 8];

    // Output slot is free when empty or emptying this cycle.
    assign own_ready = (state == XFER) && (!tx_valid || tx_ready);
    assign req_ready = own_ready ? own_oh : '0;
    assign load = own_valid && own_ready;
    assign stall = (state == XFER) && !own_valid;

    assign err_timeout = stall && (TIMEOUT != 0)
                      && (stall_cnt == TO_W'(TIMEOUT - 1));

    assign grant = (state == XFER || state == DRAIN) ? own_oh : '0;
    assign busy = (state != IDLE);

    always_comb begin
        state_n = state;
        rr_ptr_n = rr_ptr;
        owner_n = owner;
        stall_cnt_n = stall_cnt;
        gap_cnt_n = gap_cnt;
        tx_data_n = tx_data;
        tx_valid_n = tx_valid;
        err_src_n = err_src;
        unique case (state)
            IDLE: begin
                if (found) begin
                    state_n = XFER;
                    rr_ptr_n = win;
                    owner_n = win;
                    stall_cnt_n = '0;
                end
            end
            XFER: begin
                if (load) begin
                    tx_data_n = own_data;
                    tx_valid_n = 1'b1;
                    stall_cnt_n = '0;
                    if (own_last) state_n = DRAIN;
                end else begin
                    if (tx_valid && tx_ready) tx_valid_n = 1'b0;
                    if (err_timeout) begin
                        err_src_n = owner;
                        state_n = DRAIN;
                    end else if (stall) begin
                        stall_cnt_n = stall_cnt + TO_W'(1);
                    end
                end
            end
            DRAIN: begin
                if (!tx_valid || tx_ready) begin
                    tx_valid_n = 1'b0;
                    gap_cnt_n = '0;
                    state_n = (GAP_CYCLES == 0) ? IDLE : GAP;
                end
            end
            GAP: begin
                gap_cnt_n = gap_cnt + TO_W'(1);
                if (gap_cnt == TO_W'(GAP_CYCLES - 1)) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
            rr_ptr <= IW'(N_REQ - 1);
            owner <= '0;
            stall_cnt <= '0;
            gap_cnt <= '0;
            tx_data <= '0;
            tx_valid <= 1'b0;
            err_src <= '0;
        end else begin
            state <= state_n;
            rr_ptr <= rr_ptr_n;
            owner <= owner_n;
            stall_cnt <= stall_cnt_n;
            gap_cnt <= gap_cnt_n;
            tx_data <= tx_data_n;
            tx_valid <= tx_valid_n;
            err_src <= err_src_n;
        end
    end

endmodule

// File: tb/tb_tx_arbiter.sv
// Randomised bench for tx_arbiter against a packet-level round-robin model.
// dut_a: GAP=2, TIMEOUT=8; dut_b: GAP=0, TIMEOUT=0.
module tb_tx_arbiter;

    localparam int GAP_A = 2;
    localparam int TO_A = 8;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] rv [2];
    logic [1:0] rl [2];
    logic [1:0] rr [2];
    logic [1:0] gnt [2];
    logic [15:0] rd [2];
    logic [7:0] txd [2];
    logic txv [2];
    logic tr [2];
    logic bsy [2];
    logic et [2];
    logic [0:0] es [2];

    tx_arbiter #(.N_REQ(2), .GAP_CYCLES(GAP_A), .TIMEOUT(TO_A)) dut_a (
        .clk(clk), .n_rst(n_rst),
        .req_valid(rv[0]), .req_last(rl[0]), .req_data(rd[0]),
        .req_ready(rr[0]),
        .tx_data(txd[0]), .tx_valid(txv[0]), .tx_ready(tr[0]),
        .grant(gnt[0]), .busy(bsy[0]),
        .err_timeout(et[0]), .err_src(es[0])
    );

    tx_arbiter #(.N_REQ(2), .GAP_CYCLES(0), .TIMEOUT(0)) dut_b (
        .clk(clk), .n_rst(n_rst),
        .req_valid(rv[1]), .req_last(rl[1]), .req_data(rd[1]),
        .req_ready(rr[1]),
        .tx_data(txd[1]), .tx_valid(txv[1]), .tx_ready(tr[1]),
        .grant(gnt[1]), .busy(bsy[1]),
        .err_timeout(et[1]), .err_src(es[1])
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;

    logic [8:0] pq [2][2][$];
    logic [8:0] mp [2][2][$];
    logic [9:0] obs [2][$];
    logic [9:0] exp_q [2][$];
    int gaps [2][$];
    bit en [2][2];
    int trmode [2];
    int mptr [2];
    int idle_run [2];
    bit seen [2];
    bit prev_tv [2];
    bit prev_busy [2];
    bit hold [2];
    logic [7:0] held [2];
    int first_tv [2];
    int last_fire [2];
    int busy_fall [2];
    int err_n [2];
    int err_cyc [2];
    int acc_cyc [2][2];

    logic [7:0] p1 [7] = '{8'hA5, 8'h01, 8'h03, 8'h11, 8'h22, 8'h33, 8'hCC};

    always @(posedge clk) cyc++;

    function automatic logic [9:0] tag_byte(input logic [1:0] g,
                                            input logic [7:0] b);
        return {(g == 2'b01 || g == 2'b10), g[1], b};
    endfunction

    // Producers and link sink: drive at negedge, resolve handshakes just after.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 2; i++) begin
                if (en[d][i] && pq[d][i].size() > 0) begin
                    rv[d][i] = 1'b1;
                    rl[d][i] = pq[d][i][0][8];
                    rd[d][8*i +: 8] = pq[d][i][0][7:0];
                end else begin
                    rv[d][i] = 1'b0;
                    rl[d][i] = 1'b0;
                    rd[d][8*i +: 8] = 8'($urandom);
                end
            end
            case (trmode[d])
                1: tr[d] = (cyc % 4 == 0) || (cyc % 4 == 3);
                2: tr[d] = 1'($urandom_range(0, 1));
                3: tr[d] = 1'b0;
                default: tr[d] = 1'b1;
            endcase
        end
        #1;
        for (int d = 0; d < 2; d++) begin
            total++;
            assert ((rr[d] & ~gnt[d]) === 2'b00) else begin
                bad++;
                $error("FAIL ready_owner d=%0d obs=%b exp=%b", d, rr[d], rr[d] & gnt[d]);
            end
            if (hold[d]) begin
                total++;
                assert (txv[d] === 1'b1 && txd[d] === held[d]) else begin
                    bad++;
                    $error("FAIL hold d=%0d obs=%h exp=%h", d, txd[d], held[d]);
                end
            end
            hold[d] = txv[d] && !tr[d];
            held[d] = txd[d];
            if (txv[d]) begin
                if (!prev_tv[d] && seen[d]) gaps[d].push_back(idle_run[d]);
                idle_run[d] = 0;
                if (first_tv[d] < 0) first_tv[d] = cyc;
                if (tr[d]) begin
                    obs[d].push_back(tag_byte(gnt[d], txd[d]));
                    last_fire[d] = cyc;
                    seen[d] = 1'b1;
                end
            end else begin
                idle_run[d]++;
            end
            prev_tv[d] = txv[d];
            if (prev_busy[d] && !bsy[d]) busy_fall[d] = cyc;
            prev_busy[d] = bsy[d];
            if (et[d]) begin
                err_n[d]++;
                err_cyc[d] = cyc;
            end
            for (int i = 0; i < 2; i++) begin
                if (rv[d][i] && rr[d][i]) begin
                    void'(pq[d][i].pop_front());
                    acc_cyc[d][i] = cyc;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, o, e);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic add_pkt(input int d, input int i, input int len, input bit to_model);
        logic [8:0] b;
        for (int k = 0; k < len; k++) begin
            b = {k == len - 1, 8'($urandom)};
            pq[d][i].push_back(b);
            if (to_model) mp[d][i].push_back(b);
            else exp_q[d].push_back({1'b1, 1'(i), b[7:0]});
        end
    endtask

    // Whole packets in round-robin order after the last winner.
    task automatic build_exp(input int d);
        int nxt;
        logic [8:0] b;
        while (mp[d][0].size() > 0 || mp[d][1].size() > 0) begin
            nxt = mptr[d];
            do nxt = (nxt + 1) % 2; while (mp[d][nxt].size() == 0);
            do begin
                b = mp[d][nxt].pop_front();
                exp_q[d].push_back({1'b1, 1'(nxt), b[7:0]});
            end while (!b[8] && mp[d][nxt].size() > 0);
            mptr[d] = nxt;
        end
    endtask

    task automatic wait_done(input int d, input int n, input int budget, input string tag);
        int c;
        c = 0;
        while ((obs[d].size() < n || bsy[d]) && c < budget) begin
            step(1);
            c++;
        end
        chk({tag, "_wait"}, 32'(c < budget), 1);
        step(2);
    endtask

    task automatic cmp_stream(input int d, input string tag);
        chk({tag, "_len"}, obs[d].size(), exp_q[d].size());
        for (int k = 0; k < exp_q[d].size() && k < obs[d].size(); k++)
            chk($sformatf("%s[%0d]", tag, k), obs[d][k], exp_q[d][k]);
        obs[d].delete();
        exp_q[d].delete();
    endtask

    task automatic wait_err(input int d, input int e0, input string tag);
        int c;
        c = 0;
        while (err_n[d] == e0 && c < 200) begin
            step(1);
            c++;
        end
        chk({tag, "_seen"}, 32'(c < 200), 1);
    endtask

    initial begin
        int t0, e0, c, n;
        for (int d = 0; d < 2; d++) begin
            trmode[d] = 0;
            mptr[d] = 1;
            first_tv[d] = -1;
            err_n[d] = 0;
            for (int i = 0; i < 2; i++) en[d][i] = 1'b0;
        end
        step(3);
        for (int d = 0; d < 2; d++) begin
            chk("rst_tx_valid", 32'(txv[d]), 0);
            chk("rst_tx_data", 32'(txd[d]), 0);
            chk("rst_grant", 32'(gnt[d]), 0);
            chk("rst_busy", 32'(bsy[d]), 0);
            chk("rst_err", 32'(et[d]), 0);
            chk("rst_err_src", 32'(es[d]), 0);
        end
        n_rst = 1'b1;
        step(2);

        // Single known packet from producer 1.
        for (int k = 0; k < 7; k++) begin
            pq[0][1].push_back({k == 6, p1[k]});
            exp_q[0].push_back({2'b11, p1[k]});
        end
        first_tv[0] = -1;
        t0 = cyc;
        en[0][0] = 1'b1;
        en[0][1] = 1'b1;
        wait_done(0, 7, 100, "single");
        chk("single_latency", 32'(first_tv[0] - t0), 2);
        chk("single_gap", 32'(busy_fall[0] - last_fire[0]), GAP_A + 1);
        chk("single_grant", 32'(gnt[0]), 0);
        cmp_stream(0, "single");
        mptr[0] = 1;

        // Both producers queued up front with 3-byte packets.
        en[0][0] = 1'b0;
        en[0][1] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            add_pkt(0, 0, 3, 1);
            add_pkt(0, 1, 3, 1);
        end
        build_exp(0);
        seen[0] = 1'b0;
        gaps[0].delete();
        en[0][0] = 1'b1;
        en[0][1] = 1'b1;
        wait_done(0, 12, 300, "contend");
        cmp_stream(0, "contend");
        chk("contend_gaps", gaps[0].size(), 3);
        foreach (gaps[0][k]) chk("contend_gap_len", gaps[0][k], GAP_A + 2);

        // Back-pressure 1,0,0,1 then a long hold with the producer ready.
        e0 = err_n[0];
        trmode[0] = 1;
        add_pkt(0, 1, 5, 1);
        build_exp(0);
        wait_done(0, 5, 200, "bp");
        cmp_stream(0, "bp");
        trmode[0] = 3;
        add_pkt(0, 0, 4, 1);
        build_exp(0);
        step(25);
        trmode[0] = 0;
        wait_done(0, 4, 200, "hold");
        cmp_stream(0, "hold");
        chk("hold_no_err", err_n[0], e0);

        // Random packets, random link readiness.
        trmode[0] = 2;
        en[0][0] = 1'b0;
        en[0][1] = 1'b0;
        n = 0;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 2; i++) begin
                c = $urandom_range(1, 6);
                add_pkt(0, i, c, 1);
                n += c;
            end
        end
        build_exp(0);
        en[0][0] = 1'b1;
        en[0][1] = 1'b1;
        wait_done(0, n, 3000, "rand");
        cmp_stream(0, "rand");
        chk("rand_no_err", err_n[0], e0);
        trmode[0] = 0;

        // Watchdog on producer 1, truncated after 2 bytes.
        pq[0][1].push_back({1'b0, 8'($urandom)});
        pq[0][1].push_back({1'b0, 8'($urandom)});
        foreach (pq[0][1][k]) exp_q[0].push_back({2'b11, pq[0][1][k][7:0]});
        wait_err(0, e0, "wd1");
        chk("wd1_cycle", 32'(err_cyc[0] - acc_cyc[0][1]), TO_A);
        wait_done(0, 2, 100, "wd1");
        chk("wd1_count", err_n[0] - e0, 1);
        chk("wd1_src", 32'(es[0]), 1);
        cmp_stream(0, "wd1");

        // Watchdog on producer 0 while producer 1 waits.
        e0 = err_n[0];
        mptr[0] = 1;
        add_pkt(0, 0, 2, 0);
        pq[0][0][1][8] = 1'b0;
        c = 0;
        while (pq[0][0].size() > 0 && c < 50) begin
            step(1);
            c++;
        end
        chk("wd0_accept", 32'(c < 50), 1);
        add_pkt(0, 1, 3, 1);
        mptr[0] = 0;
        build_exp(0);
        wait_err(0, e0, "wd0");
        chk("wd0_cycle", 32'(err_cyc[0] - acc_cyc[0][0]), TO_A);
        wait_done(0, 5, 200, "wd0");
        chk("wd0_count", err_n[0] - e0, 1);
        chk("wd0_src", 32'(es[0]), 0);
        cmp_stream(0, "wd0");

        // Reset after three bytes of a six-byte packet.
        add_pkt(0, 0, 6, 1);
        mp[0][0].delete();
        c = 0;
        while (obs[0].size() < 3 && c < 50) begin
            step(1);
            c++;
        end
        chk("rst_mid_reach", 32'(c < 50), 1);
        n_rst = 1'b0;
        #1;
        chk("rst_mid_valid", 32'(txv[0]), 0);
        chk("rst_mid_grant", 32'(gnt[0]), 0);
        chk("rst_mid_busy", 32'(bsy[0]), 0);
        pq[0][0].delete();
        step(3);
        chk("rst_mid_bytes", obs[0].size(), 3);
        obs[0].delete();
        exp_q[0].delete();
        n_rst = 1'b1;
        mptr[0] = 1;
        en[0][0] = 1'b0;
        en[0][1] = 1'b0;
        add_pkt(0, 1, 2, 1);
        add_pkt(0, 0, 2, 1);
        build_exp(0);
        en[0][0] = 1'b1;
        en[0][1] = 1'b1;
        wait_done(0, 4, 200, "after_rst");
        cmp_stream(0, "after_rst");

        // No-gap, no-watchdog instance.
        e0 = err_n[1];
        n = 0;
        for (int k = 0; k < 2; k++) begin
            c = $urandom_range(2, 5);
            add_pkt(1, 0, c, 1);
            n += c;
        end
        build_exp(1);
        seen[1] = 1'b0;
        gaps[1].delete();
        en[1][0] = 1'b1;
        en[1][1] = 1'b1;
        wait_done(1, n, 200, "nogap");
        cmp_stream(1, "nogap");
        chk("nogap_gaps", gaps[1].size(), 1);
        if (gaps[1].size() > 0) chk("nogap_gap_len", gaps[1][0], 2);
        pq[1][0].push_back({1'b0, 8'h5A});
        exp_q[1].push_back({2'b10, 8'h5A});
        c = 0;
        while (pq[1][0].size() > 0 && c < 50) begin
            step(1);
            c++;
        end
        chk("nowd_accept", 32'(c < 50), 1);
        step(100);
        chk("nowd_no_err", err_n[1], e0);
        chk("nowd_busy", 32'(bsy[1]), 1);
        pq[1][0].push_back({1'b1, 8'hC3});
        exp_q[1].push_back({2'b10, 8'hC3});
        wait_done(1, 2, 100, "nowd");
        cmp_stream(1, "nowd");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tx_arbiter.md
Name: tx_arbiter

Overview:
Packet-atomic round-robin arbiter that shares the single byte-serial TX link between N_REQ framed packet producers, for example cmd_encoder instances and a status generator. Each producer offers a valid/ready/last byte stream. The arbiter grants one producer per packet, forwards bytes through a registered output stage, and enforces a minimum inter-packet gap. A stall watchdog aborts a granted producer that stops delivering bytes mid-packet.

Parameters:
N_REQ, 2, number of producers; must be >= 2.
GAP_CYCLES, 2, minimum idle cycles between packets on tx; 0 means no gap.
TIMEOUT, 1000, consecutive stall cycles in XFER before abort; 0 disables the watchdog; maximum 65535.

Ports:
clk  in  1  clock
n_rst  in  1  reset, asynchronous, active-low
req_valid  in  N_REQ  per-producer byte valid
req_last  in  N_REQ  per-producer last byte of packet, qualified by req_valid
req_data  in  8*N_REQ  per-producer byte; producer i uses bits [8*i+:8]
req_ready  out  N_REQ  per-producer byte accepted (combinational)
tx_data  out  8  registered output byte
tx_valid  out  1  registered output valid
tx_ready  in  1  link accepts byte when tx_valid & tx_ready
grant  out  N_REQ  one-hot current owner; zero when not in XFER/DRAIN
busy  out  1  state != IDLE
err_timeout  out  1  one-cycle pulse on watchdog abort
err_src  out  clog2(N_REQ)  index of aborted producer; holds until next abort

Behaviour:
- Reset values: tx_data=0, tx_valid=0, grant=0, busy=0, err_timeout=0, err_src=0, state=IDLE, rr_ptr=N_REQ-1 (producer 0 wins first), stall_cnt=0, gap_cnt=0.
- Reset mid-packet: immediate abandonment; no byte completes after reset is asserted. Partial packet is not resumed.
- States: IDLE, XFER, DRAIN, GAP.
- IDLE: if any req_valid, pick the first set index scanning rr_ptr+1, rr_ptr+2, ... with wrap modulo N_REQ. Next cycle: state=XFER, grant=onehot(winner), rr_ptr=winner. req_ready=0 in IDLE. Latency from req_valid to the first tx_valid is 2 cycles.
- XFER: req_ready[g] = req_valid-independent (!tx_valid | tx_ready). req_ready is 0 for every other producer.
  - On req_valid[g] & req_ready[g]: tx_data<=req_data[g], tx_valid<=1.
  - If req_last[g] is also set: state<=DRAIN.
  - Otherwise, if tx_valid & tx_ready with no load: tx_valid<=0.
- DRAIN: req_ready=0. When !tx_valid, or tx_valid & tx_ready: tx_valid<=0, grant<=0. Then state<=GAP, with gap_cnt<=0, or state<=IDLE if GAP_CYCLES=0.
- GAP: tx_valid=0, req_ready=0. Increment gap_cnt; when gap_cnt==GAP_CYCLES-1, state<=IDLE.
- Watchdog: 16-bit stall_cnt, cleared on entering XFER and on every accepted byte. It increments each XFER cycle with !req_valid[g]. Back-pressure from tx_ready is not a stall.
  - When stall_cnt==TIMEOUT-1 and TIMEOUT!=0: err_timeout=1 for one cycle, err_src<=g, state<=DRAIN.
  - Downstream then sees a truncated packet; the receiver's CRC rejects it.
- Simultaneous requests: resolved by the round-robin order only; no producer wins twice while another is waiting.
- Producer raising req_last with a zero-length packet: not legal; the first accepted byte is the prefix.
- Other producers dropping req_valid while not granted: no effect.

Decomposition:
- Shared defines header: N_REQ default; state encodings IDLE=0, XFER=1, DRAIN=2, GAP=3; TIMEOUT width 16.
- One sub-module, rr_pick: combinational. Inputs are the req vector and rr_ptr; outputs are the winner index and an any flag. The rest is a single FSM module of roughly 150–250 lines.

Test Plan:
- Single packet: producer 1 sends 0xA5,0x01,0x03,0x11,0x22,0x33,0xCC (last on 0xCC), tx_ready=1 → identical 7 bytes on tx, first tx_valid 2 cycles after req_valid, then 2 gap cycles, grant back to 0.
- Contention: producers 0 and 1 both valid from reset with 3-byte packets, held continuously → packet order 0,1,0,1; no byte interleaving within a packet; gap ≥ 2 idle cycles between packets.
- Back-pressure: tx_ready toggled 1,0,0,1 repeating during a 5-byte packet → every byte appears exactly once and in order; tx_data stable while tx_valid & !tx_ready; stall_cnt does not advance.
- Watchdog: TIMEOUT=8; producer 0 sends 2 bytes, then drops req_valid → err_timeout pulses on stall cycle 8, err_src=0, DRAIN then GAP, then producer 1 is granted if valid.
- Reset mid-packet: assert n_rst after byte 3 of 6 → tx_valid=0 and grant=0 immediately. After release, producer 0 is granted first.
- GAP_CYCLES=0, TIMEOUT=0: back-to-back packets from one producer → the next packet's first byte follows DRAIN with no idle beyond the 1-cycle arbitration; no err_timeout after a 100-cycle stall.
